// File: rtl/interval_sched_pkg.sv
// Shared definitions for the interval scheduler: FSM encoding and index-width helper.
package interval_sched_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interval_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search upward from last_owner+1 with wrap.
module rr_arbiter
  import interval_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [NUM_REQ-1:0] grant_next,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

  int unsigned idx;

  always_comb begin
    grant_next = '0;
    winner     = '0;
    any_req    = 1'b0;
    idx        = 0;
    // The last candidate visited is last_owner itself, so it has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_owner) + i) % NUM_REQ;
      if (!any_req && req[IW'(idx)]) begin
        any_req    = 1'b1;
        winner     = IW'(idx);
        grant_next = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/interval_scheduler.sv
// Shares one interval counter among NUM_REQ requesters; round-robin grant,
// count 0..target, one-cycle done pulse to the owner.
module interval_scheduler
  import interval_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  localparam int unsigned IW     = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [IW-1:0]            owner,
  output logic [WIDTH-1:0]         count
);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               busy_d;
  logic [IW-1:0]      owner_d, last_q, last_d;
  logic [WIDTH-1:0]   count_d, target_q, target_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req        (req),
    .last_owner (last_q),
    .grant_next (arb_grant),
    .winner     (arb_idx),
    .any_req    (arb_any)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      count    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      done     <= done_d;
      busy     <= busy_d;
      owner    <= owner_d;
      last_q   <= last_d;
      count    <= count_d;
      target_q <= target_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    done_d   = '0;
    owner_d  = owner;
    last_d   = last_q;
    count_d  = count;
    target_d = target_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (arb_any) begin
          state_d  = LOAD;
          grant_d  = arb_grant;
          owner_d  = arb_idx;
          target_d = len[32'(arb_idx)*WIDTH +: WIDTH];
          count_d  = '0;
        end
      end
      LOAD: begin
        if (!req[owner]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abandon wins over completion; count holds either way.
        if (!req[owner]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner;
        end else if (count == target_q) begin
          state_d = DONE;
          done_d  = grant;
        end else begin
          count_d = count + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = owner;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_interval_scheduler.sv
// Directed self-checking bench for interval_scheduler (NUM_REQ=4, WIDTH=8).
module tb_interval_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic [7:0]  count;

  int tests  = 0;
  int failed = 0;

  interval_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after the grant edge; follows the interval through DONE and the IDLE cycle.
  task automatic serve(input int who, input int l);
    logic [3:0] oh;
    oh = 4'(1 << who);
    chk("grant_at_start", 32'(grant), 32'(oh));
    chk("owner_at_start", 32'(owner), 32'(who));
    chk("count_at_start", 32'(count), 0);
    for (int c = 1; c <= l + 2; c++) begin
      tick();
      chk("grant_held", 32'(grant), 32'(oh));
      chk("done_pulse", 32'(done), (c == l + 2) ? 32'(oh) : 0);
      if (c == l + 2) chk("count_at_done", 32'(count), 32'(l));
    end
    tick();
    chk("grant_after", 32'(grant), 0);
    chk("busy_after", 32'(busy), 0);
    chk("done_after", 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    len = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_owner", 32'(owner), 0);

    // Single requester 0, len 5.
    len[7:0] = 8'd5;
    req = 4'b0001;
    tick();
    chk("r0_grant", 32'(grant), 32'b0001);
    chk("r0_busy", 32'(busy), 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("r0_count", 32'(count), 32'(k - 1));
      chk("r0_nodone", 32'(done), 0);
    end
    tick();
    chk("r0_done", 32'(done), 32'b0001);
    chk("r0_count_hold", 32'(count), 5);
    req = 4'b0000;
    tick();
    chk("r0_busy_low", 32'(busy), 0);
    chk("r0_grant_low", 32'(grant), 0);

    // Requesters 1 and 3 contend: alternate with one IDLE cycle between.
    len[15:8]  = 8'd1;
    len[31:24] = 8'd2;
    req = 4'b1010;
    tick();
    serve(1, 1);
    tick();
    serve(3, 2);
    tick();
    serve(1, 1);
    tick();
    serve(3, 2);
    req = 4'b0000;

    // Zero-length interval.
    len[23:16] = 8'd0;
    req = 4'b0100;
    tick();
    serve(2, 0);
    req = 4'b0000;

    // Requester 0 abandons at count 50 while requester 1 waits.
    len[7:0]  = 8'd200;
    len[15:8] = 8'd10;
    req = 4'b0011;
    tick();
    chk("ab_grant", 32'(grant), 32'b0001);
    for (int k = 1; k <= 51; k++) begin
      tick();
      chk("ab_nodone", 32'(done), 0);
    end
    chk("ab_count50", 32'(count), 50);
    req = 4'b0010;
    tick();
    chk("ab_idle_grant", 32'(grant), 0);
    chk("ab_idle_busy", 32'(busy), 0);
    chk("ab_idle_done", 32'(done), 0);
    chk("ab_count_hold", 32'(count), 50);
    tick();
    chk("ab_next_grant", 32'(grant), 32'b0010);
    chk("ab_next_owner", 32'(owner), 1);

    // Reset in the middle of RUN at count 3.
    for (int k = 1; k <= 4; k++) tick();
    chk("mr_count3", 32'(count), 3);
    rst = 1'b1;
    tick();
    chk("mr_grant", 32'(grant), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_count", 32'(count), 0);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk("mr_first_grant", 32'(grant), 32'b0001);
    req = 4'b0000;
    tick();
    chk("mr_load_abandon", 32'(grant), 0);
    chk("mr_load_nodone", 32'(done), 0);

    // Maximum length: count reaches 255 with no wrap, grant held 258 cycles.
    len[31:24] = 8'd255;
    req = 4'b1000;
    tick();
    serve(3, 255);
    req = 4'b0000;
    tick();
    chk("end_idle_grant", 32'(grant), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/interval_scheduler.md
# interval_scheduler

Shares a single interval-counter datapath among NUM_REQ requesters that each need a timed interval of a requester-supplied length. Round-robin arbitration grants the counter to one requester at a time, loads its interval length, runs the count to terminal, and returns a one-cycle done pulse to the owner. Sits between the requesting control blocks and the counting resource.

## Interface
- NUM_REQ, 4: number of requesters (2..16)
- WIDTH, 8: counter and interval-length width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held high until done or abandoned
- len  in  NUM_REQ*WIDTH  interval lengths; requester i at bits [i*WIDTH +: WIDTH]
- grant  out  NUM_REQ  one-hot owner of the counter, registered
- done  out  NUM_REQ  one-hot, one-cycle pulse: owner's interval complete
- busy  out  1  high whenever state is not IDLE
- owner  out  $clog2(NUM_REQ)  index of current/last owner
- count  out  WIDTH  live counter value

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if any req bit is high, select the winner round-robin, starting at index (last_owner+1) mod NUM_REQ and searching upward with wrap. Next state LOAD. Winner's len is latched into target, grant is set one-hot, and count is cleared to 0.
- LOAD: lasts one cycle. Next state RUN. If req[owner] is low, go to IDLE instead.
- RUN: each cycle with count != target, count increments by 1. When count == target, next state is DONE and count holds.
- DONE: lasts one cycle. done[owner]=1 and grant is still high. Next state IDLE, which clears grant and sets last_owner to owner.
- Abandon: if req[owner] drops during LOAD or RUN, the next edge goes to IDLE. In that case there is no done pulse, grant clears, count holds, and last_owner updates, so the abandoner loses priority.
- len changes after latching are ignored. len=0 gives one RUN cycle.
- Count arithmetic is unsigned WIDTH-bit. Count never exceeds target, so no wrap is possible.
- Reset values:
  - state IDLE
  - grant 0, done 0, busy 0
  - count 0, owner 0
  - last_owner NUM_REQ-1, so requester 0 has first priority after reset
- Reset mid-operation aborts immediately, with no done pulse.
- Requests that arrive during a non-IDLE state are not sampled until IDLE.

## Timing
- req high sampled at edge E0 (state IDLE) gives:
  - E0: grant and busy high
  - E1: RUN
  - E(2+L): DONE and done pulse high
  - E(3+L): IDLE, grant low
- Grant duration for length L: L+3 cycles. Request-to-grant latency: 1 cycle from the sampling edge.
- The owner must drop req on or before the edge that ends DONE. A req still high in the next IDLE cycle is treated as a new request. Round-robin then favours other requesters first.
- Back-to-back intervals for different requesters have exactly 1 IDLE cycle between grants.
- Abandon latency: 1 edge from req low to IDLE.

## Structure
- Shared package interval_sched_pkg holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3)
  - the helper function for the index width
- One sub-module, rr_arbiter:
  - combinational round-robin winner select from req and last_owner
  - outputs: one-hot grant_next, winner index, any_req
- The top module holds the FSM, target/count registers and output registers.

## Test plan
- Reset, then req=4'b0001 with len0=5:
  - grant=0001 on the edge after sampling
  - count runs 0..5
  - done[0] is a single pulse at cycle 7 after sampling
  - busy low at cycle 8
- Requesters 1 and 3 both held high:
  - grants alternate 1,3,1,3
  - exactly 1 IDLE cycle between grants
  - no done pulse to a non-owner
- len=0 for requester 2: RUN is one cycle; done[2] pulses 2 cycles after grant.
- Requester 0 with len=200 drops req at count=50:
  - IDLE on the next edge, no done pulse
  - count holds 50
  - pending requester 1 is granted next
- rst asserted mid-RUN (count=3):
  - next edge gives grant=0, done=0, busy=0, count=0
  - with all four requesting afterwards, requester 0 is granted first
- NUM_REQ=4, WIDTH=8, len=255: count reaches 255 without wrap; done pulses once; grant is high for 258 cycles.
